mmio_decoder: RTL and testbench
===============================

# mmio_decoder

Memory-mapped I/O decoder between the core's load/store unit and the data-side slaves (data RAM, GPIO interface, timer).
- Accepts one word request at a time over a valid/ready handshake.
- Decodes the address into exactly one slave, or flags it as an error.
- Drives a single-cycle enable with registered address and write data.
- Returns read data or a write acknowledge on a response handshake.
- The GPIO interface's `en`, `addr` and `data_in` come straight from this block's `gpio_en`, `bus_addr` and `bus_wdata`.

## Interface
Parameters:
- `RAM_BASE`, 32'h0000_0000, data RAM base address.
- `RAM_AW`, 12, log2 of RAM window size in bytes.
- `GPIO_BASE`, 32'h0001_0000, GPIO window base.
- `TIMER_BASE`, 32'h0001_0100, timer window base.
- `PER_AW`, 8, log2 of each peripheral window size in bytes.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `clk`  in  1  system clock.
  - `rst_n`  in  1  reset.
- Request channel:
  - `req_valid`  in  1  request present.
  - `req_ready`  out  1  block can accept a request.
  - `req_we`  in  1  1 = store, 0 = load.
  - `req_addr`  in  `XLEN`  byte address.
  - `req_wdata`  in  `XLEN`  store data.
- Response channel:
  - `rsp_valid`  out  1  response present.
  - `rsp_ready`  in  1  core accepts response.
  - `rsp_rdata`  out  `XLEN`  load data; 0 for stores and errors.
  - `rsp_err`  out  1  unmapped or misaligned access.
- Shared slave bus:
  - `bus_addr`  out  `XLEN`  registered request address.
  - `bus_wdata`  out  `XLEN`  registered store data.
  - `bus_we`  out  1  registered write flag.
- Slave enables and read data:
  - `ram_en`  out  1  RAM select pulse.
  - `gpio_en`  out  1  GPIO select pulse.
  - `timer_en`  out  1  timer select pulse.
  - `ram_rdata`  in  `XLEN`  RAM read data, valid one cycle after `ram_en`.
  - `gpio_rdata`  in  `XLEN`  combinational GPIO read data.
  - `timer_rdata`  in  `XLEN`  combinational timer read data.
- Status:
  - `err_count`  out  8  saturating count of error responses.

## Operation
State machine states:
- IDLE: `req_ready`=1. On `req_valid`, latch `req_we`, `req_addr` and `req_wdata` into the bus registers and latch the decoded target, then go to ACCESS.
- ACCESS: assert the target enable for this cycle only.
  - RAM load goes to WAIT.
  - Every other case goes to RESP. GPIO and timer load data is captured at the end of this cycle.
- WAIT: capture `ram_rdata` at the end of the cycle, then go to RESP.
- RESP: `rsp_valid`=1. Hold `rsp_rdata` and `rsp_err` stable until `rsp_ready`, then go to IDLE.

Address decode:
- Target matches when `addr[XLEN-1:AW] == BASE[XLEN-1:AW]`, using `RAM_AW` for RAM and `PER_AW` for GPIO and timer.
- RAM has priority if windows overlap.

Error cases:
- Error when no window matches or `addr[1:0]` is not 0.
- In ACCESS an error asserts no enable. The response then has `rsp_err`=1 and `rsp_rdata`=0.
- `err_count` increments on each accepted error response and saturates at 8'hFF.

Other rules:
- Enables are mutually exclusive and at most one cycle wide per request.
- `bus_*` keep their value after ACCESS until the next request is accepted.
- Exactly one request is in flight; `req_ready`=0 outside IDLE.

## Timing
Reset values (any point, including mid-transaction): state IDLE; every output 0 except `req_ready`=1; `err_count`=0. A pending response is discarded and the enables drop at once.

Cycle numbering, with cycle 0 as the accept edge:
- Write: enable in cycle 1; `rsp_valid` from cycle 2.
- GPIO or timer read: enable and data sample in cycle 1; `rsp_valid` from cycle 2.
- RAM read: enable in cycle 1, sample in cycle 2, `rsp_valid` from cycle 3.
- Error: no enable; `rsp_valid` from cycle 2.

Back-to-back traffic:
- With `rsp_ready` held at 1, the response is consumed on its first cycle and IDLE follows on the next cycle.
- Minimum request spacing is 3 cycles, or 4 for RAM reads.
- `rsp_ready` outside RESP is ignored.
- `req_valid` while `req_ready`=0 is ignored. The requester holds the request; nothing is latched.

## Structure
- Use `XLEN` from the shared rv_32i header.
- Put the state encoding (IDLE/ACCESS/WAIT/RESP, 2 bits) and the target encoding (NONE/RAM/GPIO/TIMER, 2 bits) as constants in the shared header.
- One sub-module, `mmio_addr_match`: a combinational window compare parameterised by BASE/AW, instantiated three times.

## Test plan
- Store 32'h0000_0001 to 32'h0001_0000 -> `gpio_en`=1 in cycle 1 only, with `bus_wdata`=1 and `bus_we`=1; `rsp_valid` in cycle 2 with `rsp_err`=0 and `rsp_rdata`=0.
- Load from 32'h0000_0010 with `ram_rdata`=32'hCAFE_F00D in cycle 2 -> `rsp_rdata`=32'hCAFE_F00D, `rsp_valid` in cycle 3.
- Load from 32'h0002_0000, then from 32'h0001_0002 -> no enable either time; `rsp_err`=1, `rsp_rdata`=0; `err_count` goes 1, then 2.
- Timer load with `timer_rdata`=32'h1234 and `rsp_ready` held 0 for 5 cycles -> `rsp_valid`, `rsp_rdata` and `req_ready`=0 stay stable; IDLE is entered the cycle after `rsp_ready`=1.
- Assert `rst_n`=0 during WAIT of a RAM load -> all enables and `rsp_valid` go to 0 immediately, `req_ready`=1 after release, and the next request behaves normally.
- 300 unmapped accesses -> `err_count` saturates at 8'hFF.

Source files
------------

// File: rtl/mmio_decoder_pkg.sv
// Shared constants for the MMIO decoder: word width, FSM state and target encodings.
package mmio_decoder_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        TGT_NONE  = 2'd0,
        TGT_RAM   = 2'd1,
        TGT_GPIO  = 2'd2,
        TGT_TIMER = 2'd3
    } target_t;

    localparam logic [7:0] ERR_COUNT_MAX = 8'hFF;

    // Misaligned addresses never reach a slave; RAM wins where windows overlap.
    function automatic target_t decode_target(
        input logic       ram_hit,
        input logic       gpio_hit,
        input logic       timer_hit,
        input logic [1:0] low_bits
    );
        target_t tgt;
        tgt = TGT_NONE;
        if (low_bits == 2'b00) begin
            if (ram_hit)        tgt = TGT_RAM;
            else if (gpio_hit)  tgt = TGT_GPIO;
            else if (timer_hit) tgt = TGT_TIMER;
        end
        return tgt;
    endfunction

endpackage

// File: rtl/mmio_decoder_if.sv
// Core-side request/response channels plus the shared slave bus of the MMIO decoder.
interface mmio_decoder_if;
    import mmio_decoder_pkg::*;

    // A transfer happens on a clock edge where valid and ready are both 1; the
    // sender holds valid and its payload stable until that edge.
    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;

    logic            rsp_valid;
    logic            rsp_ready;
    logic [XLEN-1:0] rsp_rdata;
    logic            rsp_err;

    logic [XLEN-1:0] bus_addr;
    logic [XLEN-1:0] bus_wdata;
    logic            bus_we;

    logic            ram_en;
    logic            gpio_en;
    logic            timer_en;
    logic [XLEN-1:0] ram_rdata;
    logic [XLEN-1:0] gpio_rdata;
    logic [XLEN-1:0] timer_rdata;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        input  rsp_ready,
        output bus_addr, bus_wdata, bus_we,
        output ram_en, gpio_en, timer_en,
        input  ram_rdata, gpio_rdata, timer_rdata
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        output rsp_ready,
        input  bus_addr, bus_wdata, bus_we,
        input  ram_en, gpio_en, timer_en,
        output ram_rdata, gpio_rdata, timer_rdata
    );

endinterface

// File: rtl/mmio_addr_match.sv
// Combinational window compare: hit when the address bits above AW equal those of BASE.
module mmio_addr_match
    import mmio_decoder_pkg::*;
#(
    parameter logic [XLEN-1:0] BASE = '0,
    parameter int unsigned     AW   = 12
) (
    input  logic [XLEN-1:0] addr,
    output logic            hit
);

    assign hit = ((addr >> AW) == (BASE >> AW));

endmodule

// File: rtl/mmio_decoder.sv
// Single-outstanding MMIO decoder: latches one request, pulses one slave enable, returns one response.
module mmio_decoder
    import mmio_decoder_pkg::*;
#(
    parameter logic [XLEN-1:0] RAM_BASE   = 32'h0000_0000,
    parameter int unsigned     RAM_AW     = 12,
    parameter logic [XLEN-1:0] GPIO_BASE  = 32'h0001_0000,
    parameter logic [XLEN-1:0] TIMER_BASE = 32'h0001_0100,
    parameter int unsigned     PER_AW     = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    mmio_decoder_if.slave mmio,
    output logic [7:0]  err_count,
    output logic [1:0]  dbg_state
);

    state_t  state;
    target_t target_q;
    target_t target_d;
    logic    ram_hit;
    logic    gpio_hit;
    logic    timer_hit;

    mmio_addr_match #(.BASE(RAM_BASE), .AW(RAM_AW)) u_ram_match (
        .addr (mmio.req_addr),
        .hit  (ram_hit)
    );

    mmio_addr_match #(.BASE(GPIO_BASE), .AW(PER_AW)) u_gpio_match (
        .addr (mmio.req_addr),
        .hit  (gpio_hit)
    );

    mmio_addr_match #(.BASE(TIMER_BASE), .AW(PER_AW)) u_timer_match (
        .addr (mmio.req_addr),
        .hit  (timer_hit)
    );

    assign target_d  = decode_target(ram_hit, gpio_hit, timer_hit, mmio.req_addr[1:0]);
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            target_q       <= TGT_NONE;
            mmio.req_ready <= 1'b1;
            mmio.rsp_valid <= 1'b0;
            mmio.rsp_rdata <= '0;
            mmio.rsp_err   <= 1'b0;
            mmio.bus_addr  <= '0;
            mmio.bus_wdata <= '0;
            mmio.bus_we    <= 1'b0;
            mmio.ram_en    <= 1'b0;
            mmio.gpio_en   <= 1'b0;
            mmio.timer_en  <= 1'b0;
            err_count      <= '0;
        end else begin
            // Enables are set only on the accept edge, so each lasts exactly the ACCESS cycle.
            mmio.ram_en   <= 1'b0;
            mmio.gpio_en  <= 1'b0;
            mmio.timer_en <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (mmio.req_valid) begin
                        mmio.bus_addr  <= mmio.req_addr;
                        mmio.bus_wdata <= mmio.req_wdata;
                        mmio.bus_we    <= mmio.req_we;
                        target_q       <= target_d;
                        mmio.ram_en    <= (target_d == TGT_RAM);
                        mmio.gpio_en   <= (target_d == TGT_GPIO);
                        mmio.timer_en  <= (target_d == TGT_TIMER);
                        mmio.req_ready <= 1'b0;
                        state          <= ST_ACCESS;
                    end
                end

                ST_ACCESS: begin
                    mmio.rsp_err <= (target_q == TGT_NONE);
                    if (target_q == TGT_RAM && !mmio.bus_we) begin
                        state <= ST_WAIT;
                    end else begin
                        // GPIO and timer read data is combinational while their enable is high.
                        if (!mmio.bus_we && target_q == TGT_GPIO)
                            mmio.rsp_rdata <= mmio.gpio_rdata;
                        else if (!mmio.bus_we && target_q == TGT_TIMER)
                            mmio.rsp_rdata <= mmio.timer_rdata;
                        else
                            mmio.rsp_rdata <= '0;
                        mmio.rsp_valid <= 1'b1;
                        state          <= ST_RESP;
                    end
                end

                ST_WAIT: begin
                    mmio.rsp_rdata <= mmio.ram_rdata;
                    mmio.rsp_valid <= 1'b1;
                    state          <= ST_RESP;
                end

                ST_RESP: begin
                    if (mmio.rsp_ready) begin
                        if (mmio.rsp_err && err_count != ERR_COUNT_MAX)
                            err_count <= err_count + 8'd1;
                        mmio.rsp_valid <= 1'b0;
                        mmio.rsp_rdata <= '0;
                        mmio.rsp_err   <= 1'b0;
                        mmio.req_ready <= 1'b1;
                        state          <= ST_IDLE;
                    end
                end

                default: begin
                    state          <= ST_IDLE;
                    mmio.req_ready <= 1'b1;
                end
            endcase
        end
    end

    a_enables_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0({mmio.ram_en, mmio.gpio_en, mmio.timer_en}));

    a_ready_only_idle: assert property (@(posedge clk) disable iff (!rst_n)
        mmio.req_ready == (state == ST_IDLE));

endmodule

// File: tb/tb_mmio_decoder.sv
// Directed bench for mmio_decoder: decode, latency, backpressure, errors, reset and saturation.
module tb_mmio_decoder;
    import mmio_decoder_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [7:0] err_count;
    logic [1:0] dbg_state;

    int n_vec;
    int n_miss;

    mmio_decoder_if mmio ();

    mmio_decoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mmio      (mmio),
        .err_count (err_count),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] ens();
        return {mmio.ram_en, mmio.gpio_en, mmio.timer_en};
    endfunction

    // Presents a request in IDLE; returns #1 into cycle 1 (the ACCESS cycle).
    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        int waited;
        waited = 0;
        while (!mmio.req_ready && waited < 20) begin
            tick();
            waited++;
        end
        if (!mmio.req_ready) check("ready_timeout", 32'(mmio.req_ready), 32'd1);
        mmio.req_valid = 1'b1;
        mmio.req_we    = we;
        mmio.req_addr  = addr;
        mmio.req_wdata = wdata;
        tick();
        mmio.req_valid = 1'b0;
        mmio.req_we    = 1'b0;
        mmio.req_addr  = '0;
        mmio.req_wdata = '0;
    endtask

    logic [31:0] tbl_addr [5];
    logic [2:0]  tbl_en   [5];
    logic        tbl_err  [5];

    initial begin
        n_vec  = 0;
        n_miss = 0;
        rst_n            = 1'b0;
        mmio.req_valid   = 1'b0;
        mmio.req_we      = 1'b0;
        mmio.req_addr    = '0;
        mmio.req_wdata   = '0;
        mmio.rsp_ready   = 1'b1;
        mmio.ram_rdata   = '0;
        mmio.gpio_rdata  = '0;
        mmio.timer_rdata = '0;

        tick();
        tick();
        check("rst_req_ready", 32'(mmio.req_ready), 32'd1);
        check("rst_rsp_valid", 32'(mmio.rsp_valid), 32'd0);
        check("rst_enables", 32'(ens()), 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        check("rst_bus_addr", mmio.bus_addr, 32'd0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        rst_n = 1'b1;
        tick();

        // GPIO store
        issue(1'b1, 32'h0001_0000, 32'h0000_0001);
        check("st_gpio_en", 32'(ens()), 32'b010);
        check("st_bus_wdata", mmio.bus_wdata, 32'h1);
        check("st_bus_we", 32'(mmio.bus_we), 32'd1);
        check("st_bus_addr", mmio.bus_addr, 32'h0001_0000);
        check("st_c1_rsp_valid", 32'(mmio.rsp_valid), 32'd0);
        tick();
        check("st_c2_en", 32'(ens()), 32'd0);
        check("st_c2_rsp_valid", 32'(mmio.rsp_valid), 32'd1);
        check("st_c2_rsp_err", 32'(mmio.rsp_err), 32'd0);
        check("st_c2_rsp_rdata", mmio.rsp_rdata, 32'd0);
        tick();
        check("st_c3_idle", 32'(dbg_state), 32'(ST_IDLE));
        check("st_c3_req_ready", 32'(mmio.req_ready), 32'd1);
        check("st_bus_hold", mmio.bus_wdata, 32'h1);

        // RAM load: data sampled in cycle 2, not cycle 1
        mmio.ram_rdata = 32'hDEAD_BEEF;
        issue(1'b0, 32'h0000_0010, 32'h0);
        check("ram_c1_en", 32'(ens()), 32'b100);
        check("ram_c1_bus_we", 32'(mmio.bus_we), 32'd0);
        tick();
        mmio.ram_rdata = 32'hCAFE_F00D;
        check("ram_c2_en", 32'(ens()), 32'd0);
        check("ram_c2_rsp_valid", 32'(mmio.rsp_valid), 32'd0);
        tick();
        mmio.ram_rdata = 32'h0;
        check("ram_c3_rsp_valid", 32'(mmio.rsp_valid), 32'd1);
        check("ram_c3_rdata", mmio.rsp_rdata, 32'hCAFE_F00D);
        tick();
        check("ram_c4_idle", 32'(dbg_state), 32'(ST_IDLE));

        // Unmapped then misaligned loads
        mmio.gpio_rdata = 32'hA5A5_A5A5;
        issue(1'b0, 32'h0002_0000, 32'h0);
        check("unm_en", 32'(ens()), 32'd0);
        tick();
        check("unm_rsp_valid", 32'(mmio.rsp_valid), 32'd1);
        check("unm_rsp_err", 32'(mmio.rsp_err), 32'd1);
        check("unm_rsp_rdata", mmio.rsp_rdata, 32'd0);
        tick();
        check("unm_err_count", 32'(err_count), 32'd1);
        issue(1'b0, 32'h0001_0002, 32'h0);
        check("mis_en", 32'(ens()), 32'd0);
        tick();
        check("mis_rsp_err", 32'(mmio.rsp_err), 32'd1);
        check("mis_rsp_rdata", mmio.rsp_rdata, 32'd0);
        tick();
        check("mis_err_count", 32'(err_count), 32'd2);

        // Timer load under backpressure; a stray request must be ignored
        mmio.timer_rdata = 32'h0000_1234;
        mmio.rsp_ready   = 1'b0;
        issue(1'b0, 32'h0001_0100, 32'h0);
        check("tmr_c1_en", 32'(ens()), 32'b001);
        tick();
        mmio.timer_rdata = 32'h0000_9999;
        mmio.req_valid   = 1'b1;
        mmio.req_addr    = 32'h0000_0040;
        for (int i = 0; i < 5; i++) begin
            check("bp_rsp_valid", 32'(mmio.rsp_valid), 32'd1);
            check("bp_rsp_rdata", mmio.rsp_rdata, 32'h0000_1234);
            check("bp_req_ready", 32'(mmio.req_ready), 32'd0);
            check("bp_bus_addr", mmio.bus_addr, 32'h0001_0100);
            if (i < 4) tick();
        end
        mmio.req_valid = 1'b0;
        mmio.req_addr  = '0;
        mmio.rsp_ready = 1'b1;
        tick();
        check("bp_release_idle", 32'(dbg_state), 32'(ST_IDLE));
        check("bp_release_valid", 32'(mmio.rsp_valid), 32'd0);

        // Window boundaries, driven as stores
        tbl_addr[0] = 32'h0000_0FFC; tbl_en[0] = 3'b100; tbl_err[0] = 1'b0;
        tbl_addr[1] = 32'h0000_1000; tbl_en[1] = 3'b000; tbl_err[1] = 1'b1;
        tbl_addr[2] = 32'h0001_00FC; tbl_en[2] = 3'b010; tbl_err[2] = 1'b0;
        tbl_addr[3] = 32'h0001_01FC; tbl_en[3] = 3'b001; tbl_err[3] = 1'b0;
        tbl_addr[4] = 32'h0001_0200; tbl_en[4] = 3'b000; tbl_err[4] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            issue(1'b1, tbl_addr[i], 32'h1111_0000 + 32'(i));
            check($sformatf("win%0d_en", i), 32'(ens()), 32'(tbl_en[i]));
            tick();
            check($sformatf("win%0d_err", i), 32'(mmio.rsp_err), 32'(tbl_err[i]));
            tick();
        end

        // Reset in WAIT of a RAM load
        issue(1'b0, 32'h0000_0020, 32'h0);
        check("rw_c1_en", 32'(ens()), 32'b100);
        tick();
        check("rw_c2_wait", 32'(dbg_state), 32'(ST_WAIT));
        #2;
        rst_n = 1'b0;
        #1;
        check("rw_rst_en", 32'(ens()), 32'd0);
        check("rw_rst_valid", 32'(mmio.rsp_valid), 32'd0);
        check("rw_rst_ready", 32'(mmio.req_ready), 32'd1);
        check("rw_rst_err_count", 32'(err_count), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("rw_post_ready", 32'(mmio.req_ready), 32'd1);
        mmio.gpio_rdata = 32'h0000_55AA;
        issue(1'b0, 32'h0001_0004, 32'h0);
        check("rw_post_en", 32'(ens()), 32'b010);
        tick();
        mmio.gpio_rdata = 32'h0;
        check("rw_post_valid", 32'(mmio.rsp_valid), 32'd1);
        check("rw_post_rdata", mmio.rsp_rdata, 32'h0000_55AA);
        tick();

        // Error counter saturation
        for (int i = 0; i < 300; i++) begin
            issue(1'b0, 32'h8000_0000 + 32'(i * 4), 32'h0);
            tick();
            tick();
            if (i == 253) check("sat_254", 32'(err_count), 32'hFE);
            if (i == 254) check("sat_255", 32'(err_count), 32'hFF);
        end
        check("sat_300", 32'(err_count), 32'hFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
